// File: rtl/basic_and_checker.sv
// Downstream checker for the toggle-encoded basic AND cell: shadow FSM predicts
// each cell-clock output pulse and a bounded window checks the observed pulse.
module basic_and_checker #(
  parameter int OUT_WINDOW = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clk_in,
  input  logic             out_in,
  output logic             result_valid,
  output logic             result,
  output logic             mismatch,
  output logic             protocol_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam logic [7:0]       WIN     = 8'(OUT_WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {S0, S1, S2, S3, SERR} state_e;

  // {out, clk, b, a}: capture and history stages keep running while en is low
  logic [3:0] tg_q1, tg_q2, ev;
  logic       ev_a, ev_b, ev_c, ev_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tg_q1 <= '0;
      tg_q2 <= '0;
    end else begin
      tg_q1 <= {out_in, clk_in, b_in, a_in};
      tg_q2 <= tg_q1;
    end
  end

  assign ev   = tg_q1 ^ tg_q2;
  assign ev_a = ev[0];
  assign ev_b = ev[1];
  assign ev_c = ev[2];
  assign ev_o = ev[3];

  state_e state_q, state_d;
  logic   start, exp_new, fsm_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    exp_new  = 1'b0;
    fsm_perr = 1'b0;
    if (en && state_q != SERR) begin
      if (ev_c && (ev_a || ev_b)) begin
        // hold violation: inputs moved together with the cell clock
        fsm_perr = 1'b1;
        state_d  = S0;
      end else if (ev_c) begin
        start   = 1'b1;
        exp_new = (state_q == S3);
        state_d = S0;
      end else if (ev_a && ev_b) begin
        state_d = (state_q == S0) ? S3 : SERR;
      end else if (ev_a) begin
        case (state_q)
          S0:      state_d = S1;
          S2:      state_d = S3;
          S3:      state_d = SERR;
          default: state_d = state_q;
        endcase
      end else if (ev_b) begin
        case (state_q)
          S0:      state_d = S2;
          S1:      state_d = S3;
          S3:      state_d = SERR;
          default: state_d = state_q;
        endcase
      end
      if (state_d == SERR) fsm_perr = 1'b1;
    end
  end

  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d, obs_q, obs_d, exp_q, exp_d;
  logic             done, done_obs, done_mis, win_perr;
  logic             rv_q, res_q, mis_q, perr_q;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    obs_d    = obs_q;
    exp_d    = exp_q;
    done     = 1'b0;
    done_obs = 1'b0;
    win_perr = 1'b0;
    if (en) begin
      if (start) begin
        // a new cell clock closes any open window with what it has seen so far
        done     = busy_q;
        done_obs = obs_q;
        busy_d   = 1'b1;
        cnt_d    = WIN;
        obs_d    = ev_o;
        exp_d    = exp_new;
      end else if (busy_q) begin
        if (ev_o && obs_q) win_perr = 1'b1;
        done_obs = obs_q | ev_o;
        obs_d    = done_obs;
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          done   = 1'b1;
          busy_d = 1'b0;
        end
      end else if (ev_o) begin
        win_perr = 1'b1;
      end
    end
    done_mis = done_obs ^ exp_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    if (done && !done_mis && pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
    if (done &&  done_mis && fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      obs_q  <= 1'b0;
      exp_q  <= 1'b0;
      rv_q   <= 1'b0;
      res_q  <= 1'b0;
      mis_q  <= 1'b0;
      perr_q <= 1'b0;
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      obs_q  <= obs_d;
      exp_q  <= exp_d;
      rv_q   <= done;
      res_q  <= done & done_obs;
      mis_q  <= done & done_mis;
      perr_q <= perr_q | fsm_perr | win_perr;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign result_valid = rv_q;
  assign result       = res_q;
  assign mismatch     = mis_q;
  assign protocol_err = perr_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_basic_and_checker.sv
// Scoreboard bench: a behavioural cell model predicts each check result into a
// queue; a monitor pops and compares whenever result_valid strobes.
module tb_basic_and_checker;

  localparam int W     = 8;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          a_in = 1'b0, b_in = 1'b0, clk_in = 1'b0, out_in = 1'b0;
  logic          result_valid, result, mismatch, protocol_err, busy;
  logic [CW-1:0] pass_cnt, fail_cnt;

  basic_and_checker #(.OUT_WINDOW(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_in(a_in), .b_in(b_in), .clk_in(clk_in), .out_in(out_in),
    .result_valid(result_valid), .result(result), .mismatch(mismatch),
    .protocol_err(protocol_err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit res;
    bit mis;
    int pass;
    int fail;
  } exp_t;
  exp_t sb[$];

  // cell model: which inputs have arrived since the last cell clock, plus
  // an open check window expressed as a deadline in enabled-cycle time
  int m_t, m_dl, m_pass, m_fail;
  bit m_sa, m_sb, m_err, m_open, m_obs, m_exp, m_perr;
  bit p_a, p_b, p_c, p_o;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_dl = 0; m_pass = 0; m_fail = 0;
    m_sa = 0; m_sb = 0; m_err = 0; m_open = 0; m_obs = 0; m_exp = 0; m_perr = 0;
    p_a = 0; p_b = 0; p_c = 0; p_o = 0;
  endtask

  task automatic finish_check(input bit obs);
    exp_t e;
    e.res = obs;
    e.mis = (obs != m_exp);
    if (e.mis) m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
    else       m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
    e.pass = m_pass;
    e.fail = m_fail;
    sb.push_back(e);
  endtask

  task automatic model(input bit a, input bit b, input bit c, input bit o, input bit e);
    bit start, ex, was;
    start = 0;
    ex    = 0;
    if (e) begin
      m_t++;
      if (!m_err) begin
        if (c && (a || b)) begin
          m_perr = 1; m_sa = 0; m_sb = 0;
        end else if (c) begin
          start = 1; ex = m_sa && m_sb; m_sa = 0; m_sb = 0;
        end else if (a && b) begin
          if (m_sa || m_sb) m_err = 1;
          else begin m_sa = 1; m_sb = 1; end
        end else if (a) begin
          if (m_sa && m_sb) m_err = 1; else m_sa = 1;
        end else if (b) begin
          if (m_sa && m_sb) m_err = 1; else m_sb = 1;
        end
        if (m_err) m_perr = 1;
      end
      was = m_open;
      if (start) begin
        if (was) finish_check(m_obs);
        m_open = 1; m_dl = m_t + W; m_obs = o; m_exp = ex;
      end else if (was) begin
        if (o) begin
          if (m_obs) m_perr = 1;
          m_obs = 1;
        end
        if (m_t == m_dl) begin
          finish_check(m_obs);
          m_open = 0;
        end
      end else if (o) begin
        m_perr = 1;
      end
    end
  endtask

  // one system cycle: toggles driven now are detected and judged next cycle
  task automatic step(input bit ta, input bit tb, input bit tc, input bit to, input bit e);
    @(negedge clk);
    en = e;
    model(p_a, p_b, p_c, p_o, e);
    if (ta) a_in   = ~a_in;
    if (tb) b_in   = ~b_in;
    if (tc) clk_in = ~clk_in;
    if (to) out_in = ~out_in;
    p_a = ta; p_b = tb; p_c = tc; p_o = to;
    @(posedge clk); #1;
    chk("busy", busy, m_open);
    chk("protocol_err", protocol_err, m_perr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".result_valid"}, result_valid, 0);
    chk({nm, ".result"}, result, 0);
    chk({nm, ".mismatch"}, mismatch, 0);
    chk({nm, ".protocol_err"}, protocol_err, 0);
    chk({nm, ".pass_cnt"}, pass_cnt, 0);
    chk({nm, ".fail_cnt"}, fail_cnt, 0);
    chk({nm, ".busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    rst_n = 0;
    #1 chk_all_zero("reset");
    en = 0; a_in = 0; b_in = 0; clk_in = 0; out_in = 0;
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && result_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result_valid: got 1 expected 0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("mismatch", mismatch, e.mis);
          chk("pass_cnt", pass_cnt, e.pass);
          chk("fail_cnt", fail_cnt, e.fail);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    do_reset();

    // a, b, clk, out three cycles later: expected pulse seen
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); idle(2); step(0,0,0,1,1); idle(12);
    chk("t1.pass_cnt", pass_cnt, 1);
    chk("t1.fail_cnt", fail_cnt, 0);

    // only a before clk: no pulse expected
    do_reset();
    step(1,0,0,0,1); step(0,0,1,0,1); idle(12);
    chk("t2.pass_cnt", pass_cnt, 1);
    do_reset();
    step(1,0,0,0,1); step(0,0,1,0,1); step(0,0,0,1,1); idle(12);
    chk("t2b.fail_cnt", fail_cnt, 1);

    // a, b, a: error state swallows later cell clocks
    do_reset();
    step(1,0,0,0,1); step(0,1,0,0,1); step(1,0,0,0,1); idle(2);
    chk("t3.protocol_err", protocol_err, 1);
    step(0,0,1,0,1); idle(12);
    chk("t3.pass_cnt", pass_cnt, 0);
    chk("t3.fail_cnt", fail_cnt, 0);

    // hold violation, then normal operation resumes from the idle state
    do_reset();
    step(0,1,1,0,1); idle(12);
    chk("t4.protocol_err", protocol_err, 1);
    chk("t4.busy", busy, 0);
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); step(0,0,0,1,1); idle(12);
    chk("t4.pass_cnt", pass_cnt, 1);

    // second cell clock cuts the first window short
    do_reset();
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); idle(3); step(0,0,1,0,1); idle(12);
    chk("t5.fail_cnt", fail_cnt, 1);
    chk("t5.pass_cnt", pass_cnt, 1);

    // out pulse on the last accepted cycle, and one cycle too late
    do_reset();
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); idle(7); step(0,0,0,1,1); idle(10);
    chk("t6.pass_cnt", pass_cnt, 1);
    chk("t6.protocol_err", protocol_err, 0);
    do_reset();
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); idle(8); step(0,0,0,1,1); idle(3);
    chk("t6b.fail_cnt", fail_cnt, 1);
    chk("t6b.protocol_err", protocol_err, 1);

    // enable low freezes the window and discards events
    do_reset();
    step(1,0,0,0,1); step(0,1,0,0,1); step(0,0,1,0,1); step(0,0,0,0,1);
    step(0,0,0,1,0); step(0,0,0,0,0); step(0,0,0,0,0); idle(12);
    chk("t7.fail_cnt", fail_cnt, 1);

    // saturation, then asynchronous reset in the middle of a window
    do_reset();
    for (int i = 0; i < 5; i++) begin step(0,0,1,0,1); idle(9); end
    chk("t8.pass_cnt", pass_cnt, CMAX);
    step(0,0,1,0,1); idle(3);
    chk("t8.busy_before", busy, 1);
    @(negedge clk);
    rst_n = 0;
    #1 chk_all_zero("midwin");
    sb.delete();
    model_reset();
    en = 0; a_in = 0; b_in = 0; clk_in = 0; out_in = 0;
    @(negedge clk);
    rst_n = 1;

    // randomized segments against the model
    for (int s = 0; s < 25; s++) begin
      do_reset();
      for (int i = 0; i < 50; i++)
        step($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
             $urandom_range(5) == 0, $urandom_range(7) != 0);
      idle(12);
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
